// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: permuted-choice tables, per-round
// rotation amounts and the schedule FSM state encoding.
package des_pkg;

  // Entry i (0-based) gives the DES key bit number feeding C/D bit i+1
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Encrypt rotates left, decrypt rotates right; entry r is applied to reach round r+1
  localparam logic [1:0] ENC_ROT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  localparam logic [1:0] DEC_ROT [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ks_state_t;

endpackage

// File: rtl/key_rot28.sv
// 28-bit circular rotator for one key half; index 28 holds DES bit 1,
// so a left rotate moves bit 1 to the bottom.
module key_rot28 (
  input  logic [28:1] din,
  input  logic [1:0]  amount,
  input  logic        right,
  output logic [28:1] dout
);

  always_comb begin
    dout = din;
    case (amount)
      2'd1: dout = right ? {din[1], din[28:2]}   : {din[27:1], din[28]};
      2'd2: dout = right ? {din[2:1], din[28:3]} : {din[26:1], din[28:27]};
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/key_schedule.sv
// DES round-key generator: emits 16 subkeys in encrypt or decrypt order over
// a valid/ready handshake, one rotation step per accepted subkey.
module key_schedule
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        decrypt,
  input  logic [64:1] key,
  output logic [48:1] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [4:1]  round,
  output logic        busy,
  output logic        done
);

  ks_state_t   state;
  logic [56:1] cd;
  logic [56:1] pc1;
  logic [56:1] rot_in;
  logic [56:1] rot_out;
  logic        dec;
  logic [3:0]  nidx;
  logic [1:0]  rot_amt;
  logic        rot_right;
  logic        key_parity_unused;

  // Bit numbering: DES bit n of a vector [W:1] lives at index W+1-n
  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign pc1[56-i] = key[65-PC1[i]];
  end

  for (genvar i = 0; i < 48; i++) begin : g_pc2
    assign subkey[48-i] = cd[57-PC2[i]];
  end

  assign key_parity_unused = ^{key[57], key[49], key[41], key[33],
                               key[25], key[17], key[9],  key[1]};

  // In IDLE the rotator pre-rotates the freshly permuted key for round 1;
  // in RUN it advances the registered halves by the next round's amount.
  always_comb begin
    nidx = round + 4'd1;
    if (state == IDLE) begin
      rot_in    = pc1;
      rot_amt   = decrypt ? DEC_ROT[0] : ENC_ROT[0];
      rot_right = decrypt;
    end else begin
      rot_in    = cd;
      rot_amt   = dec ? DEC_ROT[nidx] : ENC_ROT[nidx];
      rot_right = dec;
    end
  end

  key_rot28 u_rot_c (
    .din    (rot_in[56:29]),
    .amount (rot_amt),
    .right  (rot_right),
    .dout   (rot_out[56:29])
  );

  key_rot28 u_rot_d (
    .din    (rot_in[28:1]),
    .amount (rot_amt),
    .right  (rot_right),
    .dout   (rot_out[28:1])
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cd           <= '0;
      dec          <= 1'b0;
      round        <= '0;
      subkey_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cd           <= rot_out;
            dec          <= decrypt;
            round        <= '0;
            subkey_valid <= 1'b1;
            state        <= RUN;
          end
        end
        RUN: begin
          if (subkey_valid && subkey_ready) begin
            if (round == 4'd15) begin
              subkey_valid <= 1'b0;
              done         <= 1'b1;
              state        <= DONE;
            end else begin
              cd    <= rot_out;
              round <= nidx;
            end
          end
        end
        DONE: state <= IDLE;
        default: begin
          subkey_valid <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_key_schedule.sv
// Bench for key_schedule: table of known DES vectors, hand-written corner
// sequences, and random keys/backpressure against a cumulative-shift model.
module tb_key_schedule;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        decrypt;
  logic [64:1] key;
  logic [48:1] subkey;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [4:1]  round;
  logic        busy;
  logic        done;

  int nchk  = 0;
  int npass = 0;

  key_schedule dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .decrypt      (decrypt),
    .key          (key),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .round        (round),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  localparam int T_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int T_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int T_SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam logic [63:0] K0    = 64'h133457799BBCDFF1;
  localparam logic [47:0] K0_R1 = 48'h1B02EFFC7072;
  localparam logic [47:0] K0_R16 = 48'hCB3D8B0E17F5;

  // Round key r (1..16): halves left-rotated by the cumulative shift count
  function automatic logic [47:0] ref_key(input logic [63:0] k, input int r);
    logic [27:0] c, d;
    logic [55:0] cd;
    logic [47:0] o;
    int s;
    for (int i = 0; i < 28; i++) begin
      c[27-i] = k[64-T_PC1[i]];
      d[27-i] = k[64-T_PC1[i+28]];
    end
    s = 0;
    for (int j = 0; j < r; j++) s += T_SHIFT[j];
    s = s % 28;
    if (s != 0) begin
      c = (c << s) | (c >> (28 - s));
      d = (d << s) | (d >> (28 - s));
    end
    cd = {c, d};
    for (int i = 0; i < 48; i++) o[47-i] = cd[56-T_PC2[i]];
    return o;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
  endtask

  task automatic do_start(input logic [63:0] k, input logic d);
    key     = k;
    decrypt = d;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    chk("latency_valid", 64'(subkey_valid), 64'd1);
    chk("busy_run", 64'(busy), 64'd1);
  endtask

  task automatic run_sched(input logic [63:0] k, input logic d, input bit rnd,
                           output logic [47:0] first, output logic [47:0] last);
    int n, cyc;
    do_start(k, d);
    n = 0; cyc = 0; first = '0; last = '0;
    while (n < 16 && cyc < 400) begin
      chk("valid", 64'(subkey_valid), 64'd1);
      chk("subkey", 64'(subkey), 64'(ref_key(k, d ? 16 - n : n + 1)));
      chk("round", 64'(round), 64'(n));
      subkey_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (subkey_ready) begin
        if (n == 0)  first = subkey;
        if (n == 15) last  = subkey;
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    subkey_ready = 1'b0;
    chk("handshakes", 64'(n), 64'd16);
    chk("valid_fall", 64'(subkey_valid), 64'd0);
    chk("done_pulse", 64'(done), 64'd1);
    chk("busy_in_done", 64'(busy), 64'd1);
    @(negedge clk);
    chk("done_low", 64'(done), 64'd0);
    chk("busy_idle", 64'(busy), 64'd0);
  endtask

  task automatic hs(input logic [63:0] k, input int n);
    chk("hs_subkey", 64'(subkey), 64'(ref_key(k, n + 1)));
    chk("hs_round", 64'(round), 64'(n));
    subkey_ready = 1'b1;
    @(negedge clk);
    subkey_ready = 1'b0;
  endtask

  typedef struct {
    logic [63:0] key;
    logic        dec;
    logic [47:0] first;
    logic [47:0] last;
  } vec_t;

  vec_t vt [4];

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [47:0] f, l, hold;
    logic [63:0] rk;
    vt[0] = '{K0, 1'b0, K0_R1, K0_R16};
    vt[1] = '{K0, 1'b1, K0_R16, K0_R1};
    vt[2] = '{K0 ^ 64'h0101010101010101, 1'b0, K0_R1, K0_R16};
    vt[3] = '{K0 ^ 64'h0101010101010101, 1'b1, K0_R16, K0_R1};

    rst = 1'b1; start = 1'b0; decrypt = 1'b0; key = '0; subkey_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(subkey_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_round", 64'(round), 64'd0);
    chk("rst_subkey", 64'(subkey), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      run_sched(vt[v].key, vt[v].dec, 1'b0, f, l);
      chk("vec_first", 64'(f), 64'(vt[v].first));
      chk("vec_last", 64'(l), 64'(vt[v].last));
    end

    // Backpressure at round 3, then start offered in DONE must be ignored
    do_start(K0, 1'b0);
    for (int n = 0; n < 3; n++) hs(K0, n);
    hold = subkey;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("stall_subkey", 64'(subkey), 64'(hold));
      chk("stall_round", 64'(round), 64'd3);
      chk("stall_valid", 64'(subkey_valid), 64'd1);
    end
    for (int n = 3; n < 16; n++) hs(K0, n);
    chk("bp_done", 64'(done), 64'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_start_ignored", 64'(busy), 64'd0);
    chk("done_start_novalid", 64'(subkey_valid), 64'd0);
    @(negedge clk);

    // Reset at round 7 aborts; fresh start restarts from K1
    do_start(K0, 1'b0);
    for (int n = 0; n < 7; n++) hs(K0, n);
    chk("pre_rst_round", 64'(round), 64'd7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_valid", 64'(subkey_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_round", 64'(round), 64'd0);
    @(negedge clk);
    chk("abort_no_done", 64'(done), 64'd0);
    run_sched(K0, 1'b0, 1'b0, f, l);
    chk("restart_first", 64'(f), 64'(K0_R1));
    chk("restart_last", 64'(l), 64'(K0_R16));

    // Start with another key mid-run is ignored, as are key/decrypt changes
    do_start(K0, 1'b0);
    for (int n = 0; n < 5; n++) hs(K0, n);
    key = 64'hFEDCBA9876543210;
    decrypt = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("midrun_round", 64'(round), 64'd5);
    chk("midrun_busy", 64'(busy), 64'd1);
    for (int n = 5; n < 16; n++) hs(K0, n);
    chk("midrun_done", 64'(done), 64'd1);
    @(negedge clk);
    chk("midrun_done_low", 64'(done), 64'd0);

    // Random keys, direction and backpressure
    for (int t = 0; t < 8; t++) begin
      rk = {$urandom, $urandom};
      run_sched(rk, 1'($urandom_range(0, 1)), 1'b1, f, l);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/key_schedule.md
KEY_SCHEDULE -- requirements
Module: key_schedule

Interface
REQ-001 SHALL have a single clock `clk`; reset `rst` SHALL be synchronous and active-high.
REQ-002 Parameter: none. Tables and constants come from the shared package.
REQ-003 Port `clk`, input, 1 bit: rising-edge clock for all state.
REQ-004 Port `rst`, input, 1 bit: synchronous, active-high reset.
REQ-005 Port `start`, input, 1 bit: request a new 16-round schedule; sampled only in IDLE.
REQ-006 Port `decrypt`, input, 1 bit: sampled with `start`; 0 = K1..K16 order, 1 = K16..K1 order.
REQ-007 Port `key`, input, [64:1]: DES key; DES bit n maps to index (65-n); parity bits are ignored.
REQ-008 Port `subkey`, output, [48:1]: current round key, with the same bit mapping.
REQ-009 Port `subkey_valid`, output, 1 bit: `subkey` and `round` are valid.
REQ-010 Port `subkey_ready`, input, 1 bit: consumer accepts the subkey when high together with `subkey_valid`.
REQ-011 Port `round`, output, [4:1]: index of the subkey being emitted, 0..15.
REQ-012 Port `busy`, output, 1 bit: high when the block is not in IDLE.
REQ-013 Port `done`, output, 1 bit: single-cycle pulse after the 16th subkey is accepted.

Function
REQ-014 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-015 IDLE + `start`=1 -> register C/D = PC-1(`key`) rotated for round 1, latch `decrypt`, set `round`=0, go to RUN.
REQ-016 SHALL rotate as follows:
- Encrypt: left rotate 1 for rounds 1, 2, 9 and 16; left rotate 2 for all other rounds.
- Decrypt: right-rotate sequence 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- C and D SHALL be rotated independently, each as a 28-bit value.
REQ-017 `subkey` SHALL equal PC-2 of the registered C/D, computed combinationally from those registers with no extra cycle.
REQ-018 Latency: `subkey_valid`=1 SHALL first appear on the cycle after `start` is accepted.
REQ-019 RUN: `subkey_valid`=1 throughout; on `subkey_valid`&`subkey_ready`, C/D advance by the next round's rotation and `round` increments.
REQ-020 RUN with `subkey_ready`=0: `subkey`, `round` and C/D SHALL hold unchanged for any number of cycles.
REQ-021 Handshake at `round`=15 accepted -> go to DONE; `subkey_valid` SHALL fall the same edge.
REQ-022 DONE: `done`=1 for exactly one cycle, then IDLE.
REQ-023 `start` in RUN or DONE SHALL be ignored; `key`/`decrypt` changes during RUN SHALL have no effect.
REQ-024 `round` SHALL never wrap past 15; at most 16 handshakes SHALL occur per start.
REQ-025 `busy` SHALL be high in RUN and DONE, and low in IDLE.

Reset
REQ-026 When `rst`=1 at an edge, the block SHALL enter IDLE, and:
- C/D SHALL clear to 0.
- `round`=0.
- `subkey_valid`=0, `done`=0, `busy`=0.
REQ-027 Reset SHALL take priority over `start` and the handshake.
REQ-028 Reset mid-RUN SHALL abort the schedule; no `done` pulse follows.

Structure
REQ-029 Shared package `des_pkg` SHALL hold:
- the PC-1 (56-entry) and PC-2 (48-entry) tables;
- the encrypt and decrypt rotation tables (16 entries each);
- the FSM state enumeration.
REQ-030 One sub-module, `key_rot28`, SHALL rotate a 28-bit half by 0, 1 or 2 in either direction; it SHALL be instantiated twice, once for C and once for D.
REQ-031 All other logic, including the PC-2 selection, SHALL be flat in `key_schedule`.

Verification
REQ-032 Encrypt vector: `key`=0x133457799BBCDFF1, `start`, `subkey_ready`=1 -> first subkey 0x1B02EFFC7072, 16th subkey 0xCB3D8B0E17F5, then one `done` pulse.
REQ-033 Decrypt vector: same key, `decrypt`=1 -> first subkey 0xCB3D8B0E17F5, last subkey 0x1B02EFFC7072.
REQ-034 Backpressure: hold `subkey_ready`=0 for 5 cycles at `round`=3 -> `subkey` and `round`=3 stable; the full sequence is unchanged versus REQ-032.
REQ-035 Reset at `round`=7 -> next cycle `subkey_valid`=0, `busy`=0, no `done`; a fresh `start` reproduces REQ-032 from K1.
REQ-036 `start` pulsed with a different key at `round`=5 -> ignored; the remaining subkeys still match REQ-032.
REQ-037 Parity: flip all eight parity bits of the REQ-032 key -> identical 16 subkeys.
